// File: rtl/seq_divider_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seq_divider_pkg : shared state encoding and latency constants   |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
package seq_divider_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | div_step : one restoring-division iteration (shift, trial sub)  |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] w_shifted;

    assign w_shifted = {rem_in, bit_in};
    assign q_bit     = (w_shifted >= {2'b00, divisor});
    assign rem_out   = q_bit ? (w_shifted[WIDTH:0] - {1'b0, divisor})
                             : w_shifted[WIDTH:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seq_divider : multi-cycle radix-2 restoring divider (RV32M)     |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    output logic             completed,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e         r_state, w_next;
    logic [c_cnt_w-1:0] r_count;
    logic               r_sign_s, r_sign_t;
    logic [WIDTH-1:0]   r_dividend, r_divisor, r_quo;
    logic [WIDTH:0]     r_rem, w_rem_next;
    logic               w_q_bit;
    logic               r_completed;
    logic [WIDTH-1:0]   r_q, r_r;

    logic               w_sign_s, w_sign_t, w_div_zero, w_overflow;
    logic [WIDTH-1:0]   w_abs_s, w_abs_t;

    assign w_sign_s   = is_signed & s[WIDTH-1];
    assign w_sign_t   = is_signed & t[WIDTH-1];
    assign w_abs_s    = w_sign_s ? -s : s;
    assign w_abs_t    = w_sign_t ? -t : t;
    assign w_div_zero = (t == '0);
    assign w_overflow = is_signed && (s == c_min_neg) && (t == '1);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (r_rem),
        .divisor (r_divisor),
        .bit_in  (r_dividend[WIDTH-1]),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (enable) w_next = (w_div_zero || w_overflow) ? DONE : CALC;
            CALC: if (r_count == '0) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_sign_s    <= 1'b0;
            r_sign_t    <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_completed <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
        end else begin
            r_completed <= (w_next == DONE);
            case (r_state)
                IDLE: if (enable) begin
                    r_sign_s   <= w_sign_s;
                    r_sign_t   <= w_sign_t;
                    r_dividend <= w_abs_s;
                    r_divisor  <= w_abs_t;
                    r_rem      <= '0;
                    r_quo      <= '0;
                    r_count    <= c_cnt_w'(WIDTH - 1);
                    // Special cases bypass iteration and publish results immediately
                    if (w_div_zero) begin
                        r_q <= '1;
                        r_r <= s;
                    end else if (w_overflow) begin
                        r_q <= c_min_neg;
                        r_r <= '0;
                    end
                end
                CALC: begin
                    r_rem      <= w_rem_next;
                    r_quo      <= {r_quo[WIDTH-2:0], w_q_bit};
                    r_dividend <= r_dividend << 1;
                    if (r_count != '0) r_count <= r_count - 1'b1;
                end
                FIX: begin
                    r_q <= (r_sign_s ^ r_sign_t) ? -r_quo : r_quo;
                    r_r <= r_sign_s ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign completed = r_completed;
    assign q         = r_q;
    assign r         = r_r;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
